// File: rtl/dip_pkg.sv
// Shared types and default sizing for the DiP systolic array sequencing logic.
package dip_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      STREAM,
      FLUSH,
      DRAIN,
      DONE
   } ctrl_state_t;

   localparam int DIP_N        = 4;
   localparam int DIP_PIPE_LAT = 4;

endpackage

// File: rtl/step_counter.sv
// Up-counter with a terminal-count flag: the target side of the inc/isMax protocol.
module step_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] max_val,
   output logic         is_max,
   output logic [W-1:0] value
);

   logic [W-1:0] value_q;

   // A clear always wins so a phase exit on the terminal count restarts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else if (clr) begin
         value_q <= '0;
      end else if (inc) begin
         value_q <= value_q + 1'b1;
      end
   end

   assign value  = value_q;
   assign is_max = (value_q == max_val);

endmodule

// File: rtl/dip_array_ctrl.sv
// Phase sequencer for the DiP array: weight load, input streaming, pipeline
// flush and result drain, each phase ended by a step counter's terminal flag.
module dip_array_ctrl
   import dip_pkg::*;
#(
   parameter int N        = DIP_N,
   parameter int PIPE_LAT = DIP_PIPE_LAT,
   parameter int IW       = $clog2(N),
   parameter int FW       = $clog2(PIPE_LAT + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          skip_load,
   input  logic          out_ready,
   output logic          busy,
   output logic          done,
   output logic          weight_load_en,
   output logic [IW-1:0] weight_row_sel,
   output logic          input_valid,
   output logic [IW-1:0] input_row_idx,
   output logic          acc_clear,
   output logic          out_valid,
   output logic [IW-1:0] out_row_idx
);

   localparam logic [IW-1:0] ROW_MAX   = IW'(N - 1);
   localparam logic [FW-1:0] FLUSH_MAX = FW'(PIPE_LAT - 1);

   ctrl_state_t   state_q;
   ctrl_state_t   state_d;
   logic          busy_q;
   logic          done_q;
   logic          weight_load_en_q;
   logic          input_valid_q;
   logic          out_valid_q;

   logic [IW-1:0] row_val;
   logic          row_max;
   logic          row_inc;
   logic [FW-1:0] flush_val;
   logic          flush_max;
   logic          flush_inc;
   logic          cnt_clr;

   // Every phase exit is taken on a counter's is_max; only DRAIN also waits on the consumer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)                state_d = skip_load ? STREAM : LOAD_W;
         LOAD_W:  if (row_max)              state_d = STREAM;
         STREAM:  if (row_max)              state_d = FLUSH;
         FLUSH:   if (flush_max)            state_d = DRAIN;
         DRAIN:   if (row_max && out_ready) state_d = DONE;
         DONE:                              state_d = IDLE;
         default:                           state_d = IDLE;
      endcase
   end

   assign cnt_clr   = (state_d != state_q);
   assign row_inc   = (state_q == LOAD_W) || (state_q == STREAM) ||
                      ((state_q == DRAIN) && out_ready);
   assign flush_inc = (state_q == FLUSH) && (flush_val != FLUSH_MAX);

   step_counter #(.W(IW)) u_row_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (cnt_clr),
      .inc     (row_inc),
      .max_val (ROW_MAX),
      .is_max  (row_max),
      .value   (row_val)
   );

   step_counter #(.W(FW)) u_flush_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (cnt_clr),
      .inc     (flush_inc),
      .max_val (FLUSH_MAX),
      .is_max  (flush_max),
      .value   (flush_val)
   );

   // Phase flags are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         weight_load_en_q <= 1'b0;
         input_valid_q    <= 1'b0;
         out_valid_q      <= 1'b0;
      end else begin
         state_q          <= state_d;
         busy_q           <= (state_d == LOAD_W) || (state_d == STREAM) ||
                             (state_d == FLUSH)  || (state_d == DRAIN);
         done_q           <= (state_d == DONE);
         weight_load_en_q <= (state_d == LOAD_W);
         input_valid_q    <= (state_d == STREAM);
         out_valid_q      <= (state_d == DRAIN);
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign weight_load_en = weight_load_en_q;
   assign input_valid    = input_valid_q;
   assign out_valid      = out_valid_q;
   assign weight_row_sel = weight_load_en_q ? row_val : '0;
   assign input_row_idx  = input_valid_q ? row_val : '0;
   assign out_row_idx    = out_valid_q ? row_val : '0;
   assign acc_clear      = input_valid_q && (row_val == '0);

endmodule

// File: tb/tb_dip_array_ctrl.sv
// Scoreboard bench for dip_array_ctrl: an N=4/PIPE_LAT=4 instance and an
// N=2/PIPE_LAT=1 instance, one active at a time.
module tb_dip_array_ctrl;

   typedef struct {
      int   cyc;
      int   idx;
      logic clr;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic startR;
   logic skipR;
   logic readyR;
   logic activeDut;

   logic       busy1, done1, wl1, iv1, ac1, ov1;
   logic [1:0] ws1, ii1, oi1;
   logic       busy2, done2, wl2, iv2, ac2, ov2;
   logic [0:0] ws2, ii2, oi2;

   dip_array_ctrl #(.N(4), .PIPE_LAT(4)) dut1 (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (startR && !activeDut),
      .skip_load      (skipR),
      .out_ready      (readyR),
      .busy           (busy1),
      .done           (done1),
      .weight_load_en (wl1),
      .weight_row_sel (ws1),
      .input_valid    (iv1),
      .input_row_idx  (ii1),
      .acc_clear      (ac1),
      .out_valid      (ov1),
      .out_row_idx    (oi1)
   );

   dip_array_ctrl #(.N(2), .PIPE_LAT(1)) dut2 (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (startR && activeDut),
      .skip_load      (skipR),
      .out_ready      (readyR),
      .busy           (busy2),
      .done           (done2),
      .weight_load_en (wl2),
      .weight_row_sel (ws2),
      .input_valid    (iv2),
      .input_row_idx  (ii2),
      .acc_clear      (ac2),
      .out_valid      (ov2),
      .out_row_idx    (oi2)
   );

   logic       mBusy, mDone, mWl, mIv, mAc, mOv;
   logic [1:0] mWs, mIi, mOi;

   assign mBusy = activeDut ? busy2 : busy1;
   assign mDone = activeDut ? done2 : done1;
   assign mWl   = activeDut ? wl2   : wl1;
   assign mIv   = activeDut ? iv2   : iv1;
   assign mAc   = activeDut ? ac2   : ac1;
   assign mOv   = activeDut ? ov2   : ov1;
   assign mWs   = activeDut ? {1'b0, ws2} : ws1;
   assign mIi   = activeDut ? {1'b0, ii2} : ii1;
   assign mOi   = activeDut ? {1'b0, oi2} : oi1;

   int   nChecks = 0;
   int   nFail = 0;
   int   edgeNum = -1;
   int   startEdge = 0;
   int   runDoneCyc = 0;
   logic runActive = 1'b0;
   int   monCyc;
   ev_t  mE;
   ev_t  wlQ[$];
   ev_t  ivQ[$];
   ev_t  ovQ[$];
   ev_t  dnQ[$];

   task automatic checkOutput(input string name, input int act, input int want);
      nChecks++;
      if (act != want) begin
         nFail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, monCyc);
      end
   endtask

   task automatic reportUnexpected(input string name);
      nChecks++;
      nFail++;
      $display("[TB] FAIL %s: output presented at cycle %0d with nothing expected", name, monCyc);
   endtask

   task automatic checkIdle();
      checkOutput("idle_busy",  int'(mBusy), 0);
      checkOutput("idle_done",  int'(mDone), 0);
      checkOutput("idle_wl",    int'(mWl),   0);
      checkOutput("idle_wsel",  int'(mWs),   0);
      checkOutput("idle_iv",    int'(mIv),   0);
      checkOutput("idle_iidx",  int'(mIi),   0);
      checkOutput("idle_accc",  int'(mAc),   0);
      checkOutput("idle_ov",    int'(mOv),   0);
      checkOutput("idle_oidx",  int'(mOi),   0);
   endtask

   always @(posedge clk) edgeNum++;

   // Monitor: pops an expected event whenever the DUT presents the matching output.
   always @(negedge clk) begin
      monCyc = edgeNum - startEdge + 1;
      checkOutput("busy", int'(mBusy), (runActive && monCyc >= 1 && monCyc < runDoneCyc) ? 1 : 0);
      if (mWl) begin
         if (wlQ.size() == 0) reportUnexpected("weight_load_en");
         else begin
            mE = wlQ.pop_front();
            checkOutput("wl_cycle", monCyc, mE.cyc);
            checkOutput("wl_sel", int'(mWs), mE.idx);
         end
      end else checkOutput("wl_sel_idle", int'(mWs), 0);
      if (mIv) begin
         if (ivQ.size() == 0) reportUnexpected("input_valid");
         else begin
            mE = ivQ.pop_front();
            checkOutput("iv_cycle", monCyc, mE.cyc);
            checkOutput("iv_idx", int'(mIi), mE.idx);
            checkOutput("acc_clear", int'(mAc), int'(mE.clr));
         end
      end else begin
         checkOutput("iv_idx_idle", int'(mIi), 0);
         checkOutput("acc_clear_idle", int'(mAc), 0);
      end
      if (mOv) begin
         if (ovQ.size() == 0) reportUnexpected("out_valid");
         else begin
            mE = ovQ.pop_front();
            checkOutput("ov_cycle", monCyc, mE.cyc);
            checkOutput("ov_idx", int'(mOi), mE.idx);
         end
      end else checkOutput("ov_idx_idle", int'(mOi), 0);
      if (mDone) begin
         if (dnQ.size() == 0) reportUnexpected("done");
         else begin
            mE = dnQ.pop_front();
            checkOutput("done_cycle", monCyc, mE.cyc);
         end
      end
   end

   // One run: push the expected schedule, then drive start/ready/reset cycle by cycle.
   task automatic applyStimulus(input logic dut, input logic skip, input int stallStart,
                                input int stallLen, input int pulseA, input int pulseB,
                                input int resetAt, input int doneCyc);
      int  n;
      int  p;
      int  c;
      int  lim;
      bit  accepted;
      ev_t e;
      n   = dut ? 2 : 4;
      p   = dut ? 1 : 4;
      lim = (resetAt > 0) ? resetAt : 100000;
      c   = 1;
      e.clr = 1'b0;
      if (!skip) begin
         for (int i = 0; i < n; i++) begin
            e.cyc = c; e.idx = i;
            if (c < lim) wlQ.push_back(e);
            c++;
         end
      end
      for (int i = 0; i < n; i++) begin
         e.cyc = c; e.idx = i; e.clr = (i == 0);
         if (c < lim) ivQ.push_back(e);
         c++;
      end
      e.clr = 1'b0;
      c = c + p;
      for (int i = 0; i < n; i++) begin
         accepted = 1'b0;
         while (!accepted) begin
            e.cyc = c; e.idx = i;
            if (c < lim) ovQ.push_back(e);
            accepted = !(c >= stallStart && c < stallStart + stallLen);
            c++;
         end
      end
      e.cyc = doneCyc; e.idx = 0;
      if (doneCyc < lim) dnQ.push_back(e);

      activeDut  = dut;
      skipR      = skip;
      startR     = 1'b1;
      readyR     = 1'b1;
      startEdge  = edgeNum + 1;
      runDoneCyc = doneCyc;
      runActive  = 1'b1;
      for (int k = 1; k <= doneCyc + 3; k++) begin
         @(negedge clk);
         #1;
         startR = (k == pulseA) || (k == pulseB);
         skipR  = 1'b0;
         readyR = !(k >= stallStart && k < stallStart + stallLen);
         if (k == resetAt) begin
            rst_n     = 1'b0;
            runActive = 1'b0;
            #1;
            checkIdle();
         end
         if (resetAt > 0 && k == resetAt + 2) rst_n = 1'b1;
      end
      startR = 1'b0;
      readyR = 1'b1;
      checkOutput("wl_left", wlQ.size(), 0);
      checkOutput("iv_left", ivQ.size(), 0);
      checkOutput("ov_left", ovQ.size(), 0);
      checkOutput("done_left", dnQ.size(), 0);
      wlQ.delete(); ivQ.delete(); ovQ.delete(); dnQ.delete();
   endtask

   initial begin
      rst_n     = 1'b0;
      startR    = 1'b0;
      skipR     = 1'b0;
      readyR    = 1'b1;
      activeDut = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkIdle();
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      $display("[TB] nominal run");
      applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 17);
      $display("[TB] skip_load run");
      applyStimulus(1'b0, 1'b1, 0, 0, 0, 0, 0, 13);
      $display("[TB] drain backpressure at row 2");
      applyStimulus(1'b0, 1'b0, 15, 3, 0, 0, 0, 20);
      $display("[TB] start pulses in STREAM and DONE");
      applyStimulus(1'b0, 1'b0, 0, 0, 6, 17, 0, 17);
      $display("[TB] reset during FLUSH");
      applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 10, 17);
      $display("[TB] nominal run after reset");
      applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 17);
      $display("[TB] N=2 PIPE_LAT=1 run");
      applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 8);
      $display("[TB] N=2 PIPE_LAT=1 skip_load run");
      applyStimulus(1'b1, 1'b1, 0, 0, 0, 0, 0, 6);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
